// File: rtl/apb_event_sink_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_event_sink_if
// Description : APB bus bundle between the events-to-APB master and the
//               event sink completer. The master drives the request signals
//               and the completer drives the response signals.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_event_sink_if;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata,
        output pready, prdata, pslverr
    );
endinterface
`default_nettype wire

// File: rtl/apb_event_sink.sv
`default_nettype none
// ============================================================================
// Module      : apb_event_sink
// Description : APB completer that accumulates event-count writes to three
//               decoded addresses into saturating per-event totals, inserts
//               wait states before PREADY, flags undecoded accesses with
//               PSLVERR and returns the totals on reads.
//               Optional macro EVENT_SINK_RAND_WAIT_EN: wait states come from
//               an 8-bit LFSR instead of WAIT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_event_sink #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned ACC_WIDTH   = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    apb_event_sink_if.slave           apb,
    output logic [ACC_WIDTH-1:0]      total_a_o,
    output logic [ACC_WIDTH-1:0]      total_b_o,
    output logic [ACC_WIDTH-1:0]      total_c_o,
    output logic [7:0]                err_count_o
);

    localparam logic [31:0] c_ADDR_A   = 32'hABBA_0000;
    localparam logic [31:0] c_ADDR_B   = 32'hBAFF_0000;
    localparam logic [31:0] c_ADDR_C   = 32'hCAFE_0000;
    localparam logic [32:0] c_ACC_MAX  = (33'd1 << ACC_WIDTH) - 33'd1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_wcnt;
    logic [3:0]             w_wcnt_nxt;
    logic [3:0]             w_wait_target;
    logic                   r_hold;
    logic                   w_access;
    logic                   w_ready;
    logic                   w_hit_a;
    logic                   w_hit_b;
    logic                   w_hit_c;
    logic                   w_decoded;
    logic [ACC_WIDTH-1:0]   r_total_a;
    logic [ACC_WIDTH-1:0]   r_total_b;
    logic [ACC_WIDTH-1:0]   r_total_c;
    logic [ACC_WIDTH-1:0]   w_rd_total;
    logic [7:0]             r_err_count;

    // Add the full 32-bit write value to a total, clamping at all-ones.
    function automatic logic [ACC_WIDTH-1:0] f_sat_add(
        input logic [ACC_WIDTH-1:0] acc,
        input logic [31:0]          inc
    );
        logic [32:0] sum;
        sum = {{(33-ACC_WIDTH){1'b0}}, acc} + {1'b0, inc};
        if (sum > c_ACC_MAX)
            f_sat_add = {ACC_WIDTH{1'b1}};
        else
            f_sat_add = sum[ACC_WIDTH-1:0];
    endfunction

    assign w_access  = apb.psel & apb.penable;
    // r_hold keeps a transfer that straddled a reset from completing; it
    // releases only once the bus leaves the access phase.
    assign w_ready   = w_access & ~r_hold & (r_wcnt == w_wait_target);

    assign w_hit_a   = (apb.paddr == c_ADDR_A);
    assign w_hit_b   = (apb.paddr == c_ADDR_B);
    assign w_hit_c   = (apb.paddr == c_ADDR_C);
    assign w_decoded = w_hit_a | w_hit_b | w_hit_c;

`ifdef EVENT_SINK_RAND_WAIT_EN
    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Fibonacci LFSR (taps 8,6,5,4) stepped once per completed transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_lfsr <= 8'h5A;
        else if (w_ready)
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end

    assign w_wait_target = {2'b00, r_lfsr[1:0]};
`else
    assign w_wait_target = 4'(WAIT_CYCLES);
`endif

    // State, wait counter and post-reset hold registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
            r_hold  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
            if (!w_access)
                r_hold <= 1'b0;
        end
    end

    // Next state and wait count. The first access cycle is observed while
    // the FSM is still in IDLE, so it already counts as one wait cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = 4'd0;
        unique case (r_state)
            S_IDLE: begin
                if (w_access && !w_ready && !r_hold) begin
                    w_state_nxt = S_ACCESS;
                    w_wcnt_nxt  = 4'd1;
                end
            end
            S_ACCESS: begin
                if (!w_access || w_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wcnt_nxt  = r_wcnt + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Commit writes and error counts only in the PREADY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total_a   <= '0;
            r_total_b   <= '0;
            r_total_c   <= '0;
            r_err_count <= 8'd0;
        end else if (w_ready) begin
            if (!w_decoded) begin
                if (r_err_count != 8'hFF)
                    r_err_count <= r_err_count + 8'd1;
            end else if (apb.pwrite) begin
                if (w_hit_a) r_total_a <= f_sat_add(r_total_a, apb.pwdata);
                if (w_hit_b) r_total_b <= f_sat_add(r_total_b, apb.pwdata);
                if (w_hit_c) r_total_c <= f_sat_add(r_total_c, apb.pwdata);
            end
        end
    end

    // Select the total addressed by a read; undecoded reads return zero.
    always_comb begin
        w_rd_total = '0;
        if (w_hit_a)
            w_rd_total = r_total_a;
        else if (w_hit_b)
            w_rd_total = r_total_b;
        else if (w_hit_c)
            w_rd_total = r_total_c;
    end

    assign apb.pready   = w_ready;
    assign apb.pslverr  = w_ready & ~w_decoded;
    assign apb.prdata   = (w_ready && !apb.pwrite) ? 32'(w_rd_total) : 32'h0;

    assign total_a_o    = r_total_a;
    assign total_b_o    = r_total_b;
    assign total_c_o    = r_total_c;
    assign err_count_o  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_apb_event_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_event_sink
// Description : Self-checking bench for apb_event_sink. Three instances with
//               different wait-state / width settings are driven with an
//               APB setup/access sequence from a vector table, followed by
//               hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_event_sink;

    localparam logic [31:0] c_A   = 32'hABBA_0000;
    localparam logic [31:0] c_B   = 32'hBAFF_0000;
    localparam logic [31:0] c_C   = 32'hCAFE_0000;
    localparam logic [31:0] c_BAD = 32'h1234_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [31:0] prdata  [3];

    logic [15:0] t0_a, t0_b, t0_c;
    logic [7:0]  t1_a, t1_b, t1_c;
    logic [15:0] t2_a, t2_b, t2_c;
    logic [7:0]  e0, e1, e2;
    logic [31:0] tot_a [3];
    logic [31:0] tot_b [3];
    logic [31:0] tot_c [3];
    logic [7:0]  errc  [3];

    apb_event_sink_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_bind
        assign bus[g].psel    = psel[g];
        assign bus[g].penable = penable[g];
        assign bus[g].pwrite  = pwrite[g];
        assign bus[g].paddr   = paddr[g];
        assign bus[g].pwdata  = pwdata[g];
        assign pready[g]      = bus[g].pready;
        assign pslverr[g]     = bus[g].pslverr;
        assign prdata[g]      = bus[g].prdata;
    end

    assign tot_a[0] = 32'(t0_a); assign tot_b[0] = 32'(t0_b); assign tot_c[0] = 32'(t0_c);
    assign tot_a[1] = 32'(t1_a); assign tot_b[1] = 32'(t1_b); assign tot_c[1] = 32'(t1_c);
    assign tot_a[2] = 32'(t2_a); assign tot_b[2] = 32'(t2_b); assign tot_c[2] = 32'(t2_c);
    assign errc[0] = e0; assign errc[1] = e1; assign errc[2] = e2;

    apb_event_sink #(.WAIT_CYCLES(0), .ACC_WIDTH(16)) u_w0 (
        .clk(clk), .reset(reset), .apb(bus[0]),
        .total_a_o(t0_a), .total_b_o(t0_b), .total_c_o(t0_c), .err_count_o(e0));
    apb_event_sink #(.WAIT_CYCLES(2), .ACC_WIDTH(8)) u_w2 (
        .clk(clk), .reset(reset), .apb(bus[1]),
        .total_a_o(t1_a), .total_b_o(t1_b), .total_c_o(t1_c), .err_count_o(e1));
    apb_event_sink #(.WAIT_CYCLES(3), .ACC_WIDTH(16)) u_w3 (
        .clk(clk), .reset(reset), .apb(bus[2]),
        .total_a_o(t2_a), .total_b_o(t2_b), .total_c_o(t2_c), .err_count_o(e2));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle(input int d);
        psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
        paddr[d] = 32'h0; pwdata[d] = 32'h0;
    endtask

    // Setup phase with zeroed address/pwrite, then access phase until PREADY.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rd,
                        output logic err, output int ncyc);
        ncyc = 0; rd = 32'h0; err = 1'b0;
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = 32'h0; pwrite[d] = 1'b0; pwdata[d] = 32'h0;
        @(posedge clk); #1;
        penable[d] = 1'b1; paddr[d] = addr; pwrite[d] = wr; pwdata[d] = data;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (pready[d]) begin
                ncyc = n; rd = prdata[d]; err = pslverr[d];
                break;
            end
            @(posedge clk); #1;
        end
        if (ncyc == 0) begin
            checks++; errors++;
            $display("FAIL xfer_timeout dut=%0d addr=%0h no pready within 40 cycles", d, addr);
        end
        @(posedge clk); #1;
        bus_idle(d);
    endtask

    typedef struct {
        int          d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
        logic        err;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [7:0]  e;
    } vec_t;

    vec_t vt [16];

    task automatic setv(input int i, input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [31:0] rd, input logic err,
                        input int cyc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [7:0] e);
        vt[i].d = d; vt[i].wr = wr; vt[i].addr = addr; vt[i].data = data;
        vt[i].rd = rd; vt[i].err = err; vt[i].cyc = cyc;
        vt[i].a = a; vt[i].b = b; vt[i].c = c; vt[i].e = e;
    endtask

    logic [31:0] rd;
    logic        err;
    int          ncyc;

    initial begin
        for (int d = 0; d < 3; d++) bus_idle(d);

        //   idx dut wr    addr   data            rd            err   cyc a             b         c         err_count
        setv(0,  0, 1'b1, c_A,   32'h3,          32'h0,        1'b0, 1, 32'h3,        32'h0,    32'h0,    8'd0);
        setv(1,  0, 1'b1, c_B,   32'h10,         32'h0,        1'b0, 1, 32'h3,        32'h10,   32'h0,    8'd0);
        setv(2,  0, 1'b0, c_A,   32'h0,          32'h3,        1'b0, 1, 32'h3,        32'h10,   32'h0,    8'd0);
        setv(3,  0, 1'b1, c_A,   32'hFFFF_FFFF,  32'h0,        1'b0, 1, 32'hFFFF,     32'h10,   32'h0,    8'd0);
        setv(4,  0, 1'b0, c_A,   32'h0,          32'hFFFF,     1'b0, 1, 32'hFFFF,     32'h10,   32'h0,    8'd0);
        setv(5,  0, 1'b1, c_BAD, 32'h7,          32'h0,        1'b1, 1, 32'hFFFF,     32'h10,   32'h0,    8'd1);
        setv(6,  0, 1'b0, 32'hABBA_0004, 32'h0,  32'h0,        1'b1, 1, 32'hFFFF,     32'h10,   32'h0,    8'd2);
        setv(7,  0, 1'b1, c_C,   32'h20,         32'h0,        1'b0, 1, 32'hFFFF,     32'h10,   32'h20,   8'd2);
        setv(8,  0, 1'b0, c_C,   32'h0,          32'h20,       1'b0, 1, 32'hFFFF,     32'h10,   32'h20,   8'd2);
        setv(9,  1, 1'b1, c_C,   32'h5,          32'h0,        1'b0, 3, 32'h0,        32'h0,    32'h5,    8'd0);
        setv(10, 1, 1'b1, c_B,   32'hFE,         32'h0,        1'b0, 3, 32'h0,        32'hFE,   32'h5,    8'd0);
        setv(11, 1, 1'b1, c_B,   32'h4,          32'h0,        1'b0, 3, 32'h0,        32'hFF,   32'h5,    8'd0);
        setv(12, 1, 1'b0, c_B,   32'h0,          32'hFF,       1'b0, 3, 32'h0,        32'hFF,   32'h5,    8'd0);
        setv(13, 1, 1'b1, c_A,   32'h100,        32'h0,        1'b0, 3, 32'hFF,       32'hFF,   32'h5,    8'd0);
        setv(14, 2, 1'b1, c_A,   32'h1,          32'h0,        1'b0, 4, 32'h1,        32'h0,    32'h0,    8'd0);
        setv(15, 2, 1'b0, c_C,   32'h0,          32'h0,        1'b0, 4, 32'h1,        32'h0,    32'h0,    8'd0);

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_pready%0d", d), 32'(pready[d]), 32'h0);
            chk($sformatf("rst_pslverr%0d", d), 32'(pslverr[d]), 32'h0);
            chk($sformatf("rst_prdata%0d", d), prdata[d], 32'h0);
            chk($sformatf("rst_tot%0d", d), tot_a[d] | tot_b[d] | tot_c[d], 32'h0);
            chk($sformatf("rst_errc%0d", d), 32'(errc[d]), 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 16; i++) begin
            xfer(vt[i].d, vt[i].wr, vt[i].addr, vt[i].data, rd, err, ncyc);
            if (!vt[i].wr) chk($sformatf("v%0d_prdata", i), rd, vt[i].rd);
            chk($sformatf("v%0d_pslverr", i), 32'(err), 32'(vt[i].err));
            chk($sformatf("v%0d_cycles", i), 32'(ncyc), 32'(vt[i].cyc));
            chk($sformatf("v%0d_total_a", i), tot_a[vt[i].d], vt[i].a);
            chk($sformatf("v%0d_total_b", i), tot_b[vt[i].d], vt[i].b);
            chk($sformatf("v%0d_total_c", i), tot_c[vt[i].d], vt[i].c);
            chk($sformatf("v%0d_errc", i), 32'(errc[vt[i].d]), 32'(vt[i].e));
        end

        // WAIT_CYCLES=2: total_c moves only after the third access cycle
        @(posedge clk); #1;
        psel[1] = 1'b1;
        @(posedge clk); #1;
        penable[1] = 1'b1; paddr[1] = c_C; pwrite[1] = 1'b1; pwdata[1] = 32'h1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            chk($sformatf("w2_pready_c%0d", n), 32'(pready[1]), (n == 3) ? 32'h1 : 32'h0);
            chk($sformatf("w2_pslverr_c%0d", n), 32'(pslverr[1]), 32'h0);
            chk($sformatf("w2_total_c_c%0d", n), tot_c[1], 32'h5);
            @(posedge clk); #1;
        end
        bus_idle(1);
        chk("w2_total_c_after", tot_c[1], 32'h6);

        // penable without psel is ignored
        penable[0] = 1'b1; paddr[0] = c_A; pwrite[0] = 1'b1; pwdata[0] = 32'h5;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("nosel_pready", 32'(pready[0]), 32'h0);
            @(posedge clk); #1;
        end
        bus_idle(0);
        chk("nosel_total_a", tot_a[0], 32'hFFFF);
        chk("nosel_errc", 32'(errc[0]), 32'h2);

        // err_count saturates at 255
        for (int n = 0; n < 260; n++) xfer(0, 1'b1, c_BAD, 32'h1, rd, err, ncyc);
        chk("errc_sat", 32'(errc[0]), 32'hFF);
        chk("errc_sat_totals", tot_a[0], 32'hFFFF);

        // Aborted transfer: psel drops after one access cycle
        @(posedge clk); #1;
        psel[2] = 1'b1;
        @(posedge clk); #1;
        penable[2] = 1'b1; paddr[2] = c_A; pwrite[2] = 1'b1; pwdata[2] = 32'h2;
        @(negedge clk);
        chk("abort_pready", 32'(pready[2]), 32'h0);
        @(posedge clk); #1;
        bus_idle(2);
        repeat (4) begin
            @(negedge clk);
            chk("abort_pready_after", 32'(pready[2]), 32'h0);
        end
        chk("abort_total_a", tot_a[2], 32'h1);
        chk("abort_errc", 32'(errc[2]), 32'h0);

        // Reset in the middle of a wait-state sequence
        @(posedge clk); #1;
        psel[2] = 1'b1;
        @(posedge clk); #1;
        penable[2] = 1'b1; paddr[2] = c_B; pwrite[2] = 1'b1; pwdata[2] = 32'h7;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_pready", 32'(pready[2]), 32'h0);
        chk("midrst_tot0", tot_a[0] | tot_b[0] | tot_c[0], 32'h0);
        chk("midrst_tot1", tot_a[1] | tot_b[1] | tot_c[1], 32'h0);
        chk("midrst_tot2", tot_a[2] | tot_b[2] | tot_c[2], 32'h0);
        chk("midrst_errc0", 32'(errc[0]), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("midrst_hold_pready", 32'(pready[2]), 32'h0);
            @(posedge clk); #1;
        end
        bus_idle(2);
        chk("midrst_total_b", tot_b[2], 32'h0);
        xfer(2, 1'b1, c_A, 32'h9, rd, err, ncyc);
        chk("fresh_cycles", 32'(ncyc), 32'h4);
        chk("fresh_total_a", tot_a[2], 32'h9);

        // Master-style traffic: event A three times, event B once
        repeat (3) xfer(0, 1'b1, c_A, 32'h1, rd, err, ncyc);
        xfer(0, 1'b1, c_B, 32'h1, rd, err, ncyc);
        chk("master_total_a", tot_a[0], 32'h3);
        chk("master_total_b", tot_b[0], 32'h1);
        chk("master_total_c", tot_c[0], 32'h0);
        chk("master_errc", 32'(errc[0]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
